// File: rtl/text_value_fetch.sv
// Per-frame fetch of a value table from a memory read port, delivered to the
// text-overlay value table as single-cycle update strobes (optional BCD conversion).
module text_value_fetch #(
   parameter int unsigned ENTRY_COUNT = 20,
   parameter logic [23:0] BASE_ADDR   = 24'h000000,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned BCD_MODE    = 1
) (
   input  logic        CLOCK_50,
   input  logic        RST_N,
   input  logic        frameStart,
   input  logic        resetMode,
   output logic        memReq,
   output logic [23:0] memAddr,
   input  logic        memAck,
   input  logic [15:0] memData,
   output logic [23:0] ramAddress,
   output logic [15:0] ramData,
   output logic        flagReadOK,
   output logic        busy,
   output logic        timeoutErr
);

   typedef enum logic [1:0] {IDLE, REQ, CONV, EMIT} stateT;

   localparam logic [7:0]  LAST_IDX   = 8'(ENTRY_COUNT - 1);
   localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);
   localparam logic [15:0] BCD_MAX    = 16'd999;

   stateT       state;
   logic [7:0]  idx;
   logic [7:0]  timer;
   logic [9:0]  bin;
   logic [11:0] bcd;
   logic [3:0]  bitCnt;

   logic [11:0] bcdAdj;
   logic [11:0] bcdNext;
   logic [9:0]  binNext;

   // One double-dabble iteration: add 3 to every digit >= 5, then shift the
   // binary MSB into the BCD register.
   always_comb begin
      bcdAdj = bcd;
      for (int unsigned n = 0; n < 3; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5)
            bcdAdj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
      {bcdNext, binNext} = {bcdAdj, bin} << 1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         state      <= IDLE;
         memReq     <= 1'b0;
         flagReadOK <= 1'b0;
         busy       <= 1'b0;
         timeoutErr <= 1'b0;
         ramAddress <= '0;
         ramData    <= '0;
         memAddr    <= BASE_ADDR;
         idx        <= '0;
         timer      <= '0;
         bin        <= '0;
         bcd        <= '0;
         bitCnt     <= '0;
      end else if (resetMode) begin
         // Abort without touching idx, timeoutErr or the table outputs.
         state      <= IDLE;
         memReq     <= 1'b0;
         flagReadOK <= 1'b0;
         busy       <= 1'b0;
      end else begin
         flagReadOK <= 1'b0;
         case (state)
            IDLE: begin
               if (frameStart) begin
                  idx        <= '0;
                  timeoutErr <= 1'b0;
                  memAddr    <= BASE_ADDR;
                  timer      <= '0;
                  memReq     <= 1'b1;
                  busy       <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (memAck) begin
                  memReq <= 1'b0;
                  if (BCD_MODE != 0) begin
                     bin    <= (memData > BCD_MAX) ? 10'd999 : memData[9:0];
                     bcd    <= '0;
                     bitCnt <= '0;
                     state  <= CONV;
                  end else begin
                     ramData    <= memData;
                     ramAddress <= {16'h0000, idx};
                     flagReadOK <= 1'b1;
                     state      <= EMIT;
                  end
               end else if (timer == TIMER_LAST) begin
                  timeoutErr <= 1'b1;
                  memReq     <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            CONV: begin
               bin    <= binNext;
               bcd    <= bcdNext;
               bitCnt <= bitCnt + 4'd1;
               if (bitCnt == 4'd9) begin
                  ramData    <= {4'h0, bcdNext};
                  ramAddress <= {16'h0000, idx};
                  flagReadOK <= 1'b1;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (idx == LAST_IDX) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx     <= idx + 8'd1;
                  memAddr <= BASE_ADDR + {16'h0000, idx} + 24'd1;
                  timer   <= '0;
                  memReq  <= 1'b1;
                  state   <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
